// File: rtl/header_scan_aligner.sv
// Sync-header search and lock for a 64b/66b gearbox buffer: tests LANES candidate
// positions per valid word, locks after LOCK_CNT good headers, drops lock on windowed errors.
//
// state     | meaning
// ST_SEARCH | sweeping candidate groups, per-lane run/dead tracking
// ST_LOCKED | monitoring header at offset_pos, windowed bad-header count
module header_scan_aligner #(
    parameter int BUF_W      = 194,
    parameter int NUM_POS    = 66,
    parameter int POS_W      = 7,
    parameter int LANES      = 4,
    parameter int LOCK_CNT   = 32,
    parameter int WIN_LEN    = 64,
    parameter int UNLOCK_CNT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BUF_W-1:0] gbox_buffer,
    input  logic             buffer_dv,
    input  logic             force_resync,
    output logic             is_synced,
    output logic [POS_W-1:0] offset_pos,
    output logic             header_ok,
    output logic             sync_lost,
    output logic [7:0]       sweep_cnt
);
    localparam int CW = $clog2(NUM_POS + LANES);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cand_q, cand_d;
    logic [RW-1:0]    run_q [LANES];
    logic [RW-1:0]    run_d [LANES];
    logic [LANES-1:0] dead_q, dead_d;
    logic [WW-1:0]    win_q, win_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [POS_W-1:0] offset_pos_q, offset_pos_d;
    logic             header_ok_q, header_ok_d;
    logic             sync_lost_q, sync_lost_d;
    logic [7:0]       sweep_cnt_q, sweep_cnt_d;

    logic [LANES-1:0] lane_live, lane_vld, lane_hit, lane_dead_n;
    logic [RW-1:0]    run_inc [LANES];
    logic [CW-1:0]    lock_lane, cand_step;
    logic [1:0]       lock_hdr;
    logic [BW-1:0]    bad_n;
    logic             lock_hit, all_dead, lock_vld, unlock_hit, clr_lanes;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [CW-1:0] pos;
        logic [1:0]    hdr;
        assign pos            = cand_q + CW'(g);
        assign hdr            = 2'(gbox_buffer >> pos);
        assign lane_live[g]   = (pos < CW'(NUM_POS)) && !dead_q[g];
        assign lane_vld[g]    = hdr[0] ^ hdr[1];
        assign run_inc[g]     = run_q[g] + RW'(1);
        assign lane_hit[g]    = lane_live[g] && lane_vld[g] && (run_inc[g] == RW'(LOCK_CNT));
        assign lane_dead_n[g] = !(lane_live[g] && lane_vld[g]);
    end

    // Lowest-index hitting lane wins the lock.
    always_comb begin
        lock_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_hit[i]) lock_lane = CW'(i);
        end
    end

    assign lock_hit   = |lane_hit;
    assign all_dead   = &lane_dead_n;
    assign cand_step  = cand_q + CW'(LANES);
    assign lock_hdr   = 2'(gbox_buffer >> offset_pos_q);
    assign lock_vld   = lock_hdr[0] ^ lock_hdr[1];
    assign bad_n      = lock_vld ? bad_q : bad_q + BW'(1);
    assign unlock_hit = (bad_n == BW'(UNLOCK_CNT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_SEARCH;
            cand_q       <= '0;
            for (int i = 0; i < LANES; i++) run_q[i] <= '0;
            dead_q       <= '0;
            win_q        <= '0;
            bad_q        <= '0;
            offset_pos_q <= '0;
            header_ok_q  <= 1'b0;
            sync_lost_q  <= 1'b0;
            sweep_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            run_q        <= run_d;
            dead_q       <= dead_d;
            win_q        <= win_d;
            bad_q        <= bad_d;
            offset_pos_q <= offset_pos_d;
            header_ok_q  <= header_ok_d;
            sync_lost_q  <= sync_lost_d;
            sweep_cnt_q  <= sweep_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (force_resync) begin
            state_d = ST_SEARCH;
        end else if (buffer_dv) begin
            case (state_q)
                ST_SEARCH: if (lock_hit) state_d = ST_LOCKED;
                ST_LOCKED: if (unlock_hit) state_d = ST_SEARCH;
                default:   state_d = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        cand_d       = cand_q;
        run_d        = run_q;
        dead_d       = dead_q;
        win_d        = win_q;
        bad_d        = bad_q;
        offset_pos_d = offset_pos_q;
        header_ok_d  = header_ok_q;
        sync_lost_d  = 1'b0;
        sweep_cnt_d  = sweep_cnt_q;
        clr_lanes    = 1'b0;
        if (force_resync) begin
            cand_d      = '0;
            win_d       = '0;
            bad_d       = '0;
            header_ok_d = 1'b0;
            clr_lanes   = 1'b1;
        end else if (buffer_dv) begin
            if (state_q == ST_SEARCH) begin
                header_ok_d = 1'b0;
                if (lock_hit) begin
                    offset_pos_d = POS_W'(cand_q + lock_lane);
                    win_d        = '0;
                    bad_d        = '0;
                    clr_lanes    = 1'b1;
                end else if (all_dead) begin
                    clr_lanes = 1'b1;
                    if (cand_step >= CW'(NUM_POS)) begin
                        cand_d = '0;
                        if (sweep_cnt_q != 8'hFF) sweep_cnt_d = sweep_cnt_q + 8'd1;
                    end else begin
                        cand_d = cand_step;
                    end
                end else begin
                    for (int i = 0; i < LANES; i++) run_d[i] = lane_vld[i] ? run_inc[i] : '0;
                    dead_d = lane_dead_n;
                end
            end else begin
                header_ok_d = lock_vld;
                if (unlock_hit) begin
                    sync_lost_d = 1'b1;
                    cand_d      = '0;
                    win_d       = '0;
                    bad_d       = '0;
                    clr_lanes   = 1'b1;
                end else if (win_q == WW'(WIN_LEN - 1)) begin
                    // Final word's bad header was already tested above, then the window restarts.
                    win_d = '0;
                    bad_d = '0;
                end else begin
                    win_d = win_q + WW'(1);
                    bad_d = bad_n;
                end
            end
        end
        if (clr_lanes) begin
            for (int i = 0; i < LANES; i++) run_d[i] = '0;
            dead_d = '0;
        end
    end

    always_comb begin
        is_synced  = (state_q == ST_LOCKED);
        offset_pos = offset_pos_q;
        header_ok  = header_ok_q;
        sync_lost  = sync_lost_q;
        sweep_cnt  = sweep_cnt_q;
    end
endmodule

// File: doc/header_scan_aligner.md
# header_scan_aligner

Parametrised successor to the hierarchical header seeker for the RD53B Aurora 64b/66b receive path. Sits after the gearbox: each valid buffer word it tests LANES candidate sync-header positions in parallel, sweeps the candidate window group by group, locks on the first position with LOCK_CNT consecutive valid headers, then monitors the locked position and drops lock on excessive header errors (lock/unlock hysteresis the previous seeker lacked). Provides offset and lock status to the descrambler/frame extractor.

## Interface
- BUF_W, 194: gearbox buffer width
- NUM_POS, 66: candidate positions 0..NUM_POS-1; require NUM_POS+1 <= BUF_W
- POS_W, 7: width of offset_pos; require 2**POS_W >= NUM_POS
- LANES, 4: candidates tested per word (1..NUM_POS)
- LOCK_CNT, 32: consecutive valid headers needed to lock (>=1)
- WIN_LEN, 64: monitor window length in dv words
- UNLOCK_CNT, 16: bad headers within one window that cause lock loss (1..WIN_LEN)
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- gbox_buffer  in  BUF_W  buffer; header at position p = gbox_buffer[p+1:p]
- buffer_dv  in  1  gbox_buffer valid this cycle
- force_resync  in  1  single-cycle request to restart search
- is_synced  out  1  locked
- offset_pos  out  POS_W  locked header position
- header_ok  out  1  registered header validity at offset_pos (LOCKED only, else 0)
- sync_lost  out  1  one-cycle pulse on lock loss
- sweep_cnt  out  8  completed full sweeps, saturating at 255

## Operation
- Header valid iff its two bits differ (01 or 10).
- States: SEARCH, LOCKED. All state advances only on buffer_dv=1 cycles.
- SEARCH: base pointer cand (starts 0, steps by LANES). Lane i tests position cand+i; lanes with cand+i >= NUM_POS are disabled (permanently dead).
- Per lane: run counter (clog2(LOCK_CNT+1) bits) and sticky dead bit, cleared on group entry. Valid header: run+1; invalid: run=0, dead=1.
- Lock: if any live lane's run reaches LOCK_CNT this word, lowest-index such lane wins; offset_pos <= cand+i, go LOCKED. Lock check takes priority over group advance.
- Advance: when all lanes dead (after this word's update) and no lock, cand += LANES; if new cand >= NUM_POS then cand = 0 and sweep_cnt++ (saturating).
- LOCKED: window counter w (0..WIN_LEN-1) and bad counter b. Each dv word: header_ok <= valid(offset_pos); bad -> b+1. If b reaches UNLOCK_CNT: sync_lost pulse, go SEARCH with cand=0, clear lane state. Else if w == WIN_LEN-1: w=0, b=0 (final word's bad counted before clear).
- force_resync (any state, any cycle, dv not required): go SEARCH, cand=0, clear lanes/counters; is_synced drops; no sync_lost pulse; sweep_cnt kept. Overrides a simultaneous lock or unlock.
- offset_pos holds last locked value while in SEARCH.

## Timing
- All outputs registered. Reset values: is_synced 0, offset_pos 0, header_ok 0, sync_lost 0, sweep_cnt 0; state SEARCH, cand 0, all counters 0.
- Lock: is_synced and offset_pos update the cycle after the dv word completing LOCK_CNT.
- Unlock: is_synced 0 and sync_lost 1 the cycle after the UNLOCK_CNT-th bad word; sync_lost high exactly one cycle.
- header_ok updates one cycle after each LOCKED dv word; 0 in SEARCH.
- force_resync: is_synced 0 next cycle.
- rst_i asserted mid-operation: all registers to reset values immediately, asynchronously; release synchronous to clk_i by upstream.
- buffer_dv=0: all state held, sync_lost 0.

## Test plan
- Background all zeros, header at 37 alternating 01/10 per word (bits 38:37), defaults: groups 0..32 die in one word each; group 36 entered on dv #10; lanes 36/38 die within 2 words; is_synced=1, offset_pos=37 the cycle after dv #41.
- Locked on 37, corrupt 16 consecutive headers -> sync_lost one-cycle pulse and is_synced=0 after 16th bad word; rerun with 15 bad then clean -> stays locked, header_ok=0 for exactly 15 words.
- Locked, 15 bad in window 1, 1 bad at start of window 2 -> stays locked (window clear verified).
- All-zero buffer forever -> sweep_cnt increments every 17 dv words (groups 0..64, lanes 66/67 disabled), saturates at 255.
- force_resync same cycle as lock-completing word -> no lock, cand=0, is_synced stays 0, no sync_lost.
- rst_i pulsed mid-search and while locked (no clock edge) -> all outputs reset immediately; relock after dv #41 as in scenario 1.
